// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory responder.
// Provides the responder FSM state type, word width and latency counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word RAM, DEPTH x 32: synchronous write, asynchronous read.
// Ports: clk, we, addr (word index), wdata, rdata.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the core for LATENCY+1 cycles.
// Ports: clk, reset (async low), dmem_* request/response, misalign_err, stall_cycles.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [WORD_W-1:0] dmem_addr,
  input  logic [WORD_W-1:0] dmem_write_data,
  output logic [WORD_W-1:0] dmem_read_data,
  output logic              dmem_stall,
  output logic              misalign_err,
  output logic [WORD_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  resp_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] mem_rdata;
  logic              req;
  logic              access;
  logic              mem_we;

  // Address bits above the word index alias and are ignored.
  logic addr_unused;
  assign addr_unused = ^dmem_addr[WORD_W-1:AW+2];

  assign req    = dmem_read | dmem_write;
  assign access = (state == BUSY) && (cnt == '0);
  assign mem_we = access & op_wr;

  always_comb begin
    dmem_stall = 1'b0;
    if (reset) begin
      unique case (1'b1)
        state == IDLE: dmem_stall = req;
        state == BUSY: dmem_stall = 1'b1;
        default:       dmem_stall = 1'b0;
      endcase
    end
  end

  assign dmem_read_data = rdata_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      op_wr        <= 1'b0;
      idx          <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= dmem_write;
            idx     <= dmem_addr[AW+1:2];
            wdata_q <= dmem_write_data;
            cnt     <= CNT_INIT;
            state   <= BUSY;
            if (dmem_addr[1:0] != 2'b00) misalign_err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Write data is echoed so DONE always shows the accessed word.
            rdata_q <= op_wr ? wdata_q : mem_rdata;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (dmem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts load/store requests and returns read data after a configurable latency.
- Stalls the core through a handshake while the access is in flight.
- Replaces the single-cycle data memory in the top level, so pipeline stall logic can be exercised against realistic multi-cycle memory timing.
- Also flags misaligned accesses and counts stall cycles for performance measurement.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; power of two.
- AW, 6, word-index width; equals log2(DEPTH).
- LATENCY, 2, BUSY-phase length in cycles; legal range 1..15.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- dmem_read  input  1  load request from the core.
- dmem_write  input  1  store request from the core.
- dmem_addr  input  32  byte address from the core's ALU result.
- dmem_write_data  input  32  store data.
- dmem_read_data  output  32  load data; valid only in DONE.
- dmem_stall  output  1  holds the core's pipeline while high.
- misalign_err  output  1  sticky flag: an access had addr[1:0] != 0.
- stall_cycles  output  32  saturating count of cycles with dmem_stall = 1.

Behaviour:
- Reset values while reset = 0:
  - state = IDLE; dmem_stall = 0 (forced low during reset); dmem_read_data = 0; misalign_err = 0; stall_cycles = 0; internal counter = 0.
  - Array contents are not reset.
- Request: req = dmem_read | dmem_write. If both are high, it is treated as a write and misalign_err is not affected by this rule.
- States:
  - IDLE:
    - dmem_stall = req (combinational).
    - On req: latch op, word index dmem_addr[AW+1:2] and write data; load cnt = LATENCY-1; go to BUSY.
    - If dmem_addr[1:0] != 0 on acceptance, set misalign_err. The access still uses the aligned word.
  - BUSY:
    - dmem_stall = 1.
    - If cnt != 0: decrement cnt.
    - If cnt == 0: perform the access at this edge (write commits to the array, or the read word is captured into rdata_q); go to DONE.
  - DONE:
    - dmem_stall = 0; dmem_read_data = rdata_q (after a write, rdata_q holds the written word).
    - Next edge: go to IDLE unconditionally. The core has advanced by then.
- Latency: a request first seen in IDLE at cycle T gives dmem_stall = 1 for cycles T..T+LATENCY and dmem_stall = 0 at T+LATENCY+1 (DONE). Total access time is LATENCY+2 cycles.
- Back-to-back requests: the next request is evaluated in IDLE at T+LATENCY+2. There is no pipelining: one outstanding access at a time.
- Request dropped or changed mid-BUSY (for example a flush): the latched access completes as captured and writes still commit. The new inputs are ignored until IDLE.
- Address wrap: the index uses only dmem_addr[AW+1:2], so higher bits alias. No error is raised for out-of-range addresses.
- dmem_read_data outside DONE: holds its last value (rdata_q is registered); it is not valid.
- stall_cycles: increments on every edge where dmem_stall = 1 and reset = 1. It saturates at 0xFFFF_FFFF.
- Reset asserted mid-operation: returns immediately to IDLE with all outputs at their reset values. An uncommitted write is dropped. Array words already written are retained.
- Read-after-write to the same word in consecutive accesses: the read returns the new data, because the write commits before the read is captured.

Decomposition:
- Package mem_pkg contains:
  - enum resp_state_t {IDLE, BUSY, DONE} (2 bits);
  - localparam WORD_W = 32;
  - localparam CNT_W = 4 (sized to hold 15).
- One sub-module, dmem_array: synchronous-write, asynchronous-read word RAM (DEPTH x 32).
- dmem_responder holds the FSM, request latch, counters and error logic.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to 0x40 -> dmem_stall high for 3 cycles, low on the 4th; a following load from 0x40 (after a 1-cycle IDLE) returns 0xDEADBEEF in its DONE cycle.
- Load from 0x42 -> misalign_err rises to 1 and stays 1 through later aligned accesses; the data returned is the word at 0x40.
- Store 0x11111111 to 0x00, then drop dmem_write in the 2nd BUSY cycle and raise a load of 0x04 -> the store still commits and the dropped load is ignored; a later load from 0x00 returns 0x11111111.
- Address alias, DEPTH=64: store 0xA5A5A5A5 to 0x100 -> a load from 0x000 returns 0xA5A5A5A5.
- Reset (reset=0) in the 1st BUSY cycle of a store of 0x22222222 to 0x08 -> dmem_stall = 0 and stall_cycles = 0 immediately; after release, a load from 0x08 returns the prior value, not 0x22222222.
- Ten back-to-back loads, LATENCY=2 -> stall_cycles = 30, and each load takes exactly 4 cycles from IDLE to IDLE.
